// File: rtl/mem_pkg.sv
// Shared definitions for the main memory model: FSM state encoding,
// default bus widths, wait-counter width and access-statistics constants.
// Imported by main_memory and mem_array.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int D_WIDTH = 8;
  localparam int A_WIDTH = 8;

  // Wait counter covers wait_cycles up to 15.
  localparam int CNT_W = 4;

  // Access statistics counters saturate instead of wrapping.
  localparam int                STAT_W   = 16;
  localparam logic [STAT_W-1:0] STAT_SAT = 16'hFFFF;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == STAT_SAT) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Purpose: word-addressed storage array behind the main memory FSM.
// Latency: write lands at the strobe edge; read data registered, valid one edge after re.
// Backpressure: none; accepts one strobe per cycle, contents survive clr.
// Ports: clk/clr (clr clears only the read register), we/re commit strobes,
//        addr word address, wdata write data, rdata registered read data.
module mem_array #(
  parameter int d_width = 8,
  parameter int a_width = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               we,
  input  logic               re,
  input  logic [a_width-1:0] addr,
  input  logic [d_width-1:0] wdata,
  output logic [d_width-1:0] rdata
);

  logic [d_width-1:0] mem [0:(1<<a_width)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/main_memory.sv
// Purpose: slow backing RAM answering cache write-backs and line fills on a shared tri-state bus.
// Latency: wait_cycles+1 posedges from request capture to rdy; held requests are not re-committed.
// Backpressure: busy while an access is pending; rdy once committed; dropping ce_in before commit aborts.
// Ports: clk, clr (sync active-high), addr_in, data_io (inout), rw_in (1=read), ce_in,
//        rdy (committed), busy (pending).
// Optional: MAIN_MEMORY_STATS_EN adds saturating 16-bit rd_count / wr_count outputs.
module main_memory
  import mem_pkg::*;
#(
  parameter int d_width     = D_WIDTH,
  parameter int a_width     = A_WIDTH,
  parameter int wait_cycles = 0
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [a_width-1:0] addr_in,
  inout  wire  [d_width-1:0] data_io,
  input  logic               rw_in,
  input  logic               ce_in,
  output logic               rdy,
  output logic               busy
`ifdef MAIN_MEMORY_STATS_EN
  ,
  output logic [STAT_W-1:0]  rd_count,
  output logic [STAT_W-1:0]  wr_count
`endif
);

  localparam logic [CNT_W-1:0] CNT_LOAD =
    (wait_cycles == 0) ? '0 : CNT_W'(wait_cycles - 1);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [a_width-1:0] addr_l, addr_l_nx;
  logic               rw_l, rw_l_nx;
  logic [d_width-1:0] data_l, data_l_nx;
  logic [d_width-1:0] rd_reg;

  // Commit strobe and the access it applies to. With wait_cycles=0 the
  // commit happens at the capture edge, so it uses the live bus values
  // rather than the latches that are only being loaded on that edge.
  logic               commit;
  logic [a_width-1:0] c_addr;
  logic               c_rw;
  logic [d_width-1:0] c_data;
  logic               new_req;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    addr_l_nx = addr_l;
    rw_l_nx   = rw_l;
    data_l_nx = data_l;
    commit    = 1'b0;
    c_addr    = addr_l;
    c_rw      = rw_l;
    c_data    = data_l;

    // A request that differs from the one being held is a fresh access.
    new_req = ce_in && ((state == IDLE) ||
              ((state == HOLD) && ((addr_in != addr_l) || (rw_in != rw_l))));

    case (state)
      WAIT: begin
        if (cnt == '0) begin
          // Commit completes even if ce_in falls on this edge.
          commit   = 1'b1;
          state_nx = ce_in ? HOLD : IDLE;
        end else if (!ce_in) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        if (!ce_in) begin
          state_nx = IDLE;
        end
      end
      IDLE: ;
      default: state_nx = IDLE;
    endcase

    if (new_req) begin
      addr_l_nx = addr_in;
      rw_l_nx   = rw_in;
      data_l_nx = rw_in ? data_l : data_io;
      if (wait_cycles == 0) begin
        commit   = 1'b1;
        c_addr   = addr_in;
        c_rw     = rw_in;
        c_data   = data_io;
        state_nx = HOLD;
      end else begin
        cnt_nx   = CNT_LOAD;
        state_nx = WAIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_l <= '0;
      rw_l   <= 1'b0;
      data_l <= '0;
      rdy    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      addr_l <= addr_l_nx;
      rw_l   <= rw_l_nx;
      data_l <= data_l_nx;
      rdy    <= (state_nx == HOLD);
      busy   <= (state_nx == WAIT);
    end
  end

  mem_array #(
    .d_width (d_width),
    .a_width (a_width)
  ) u_array (
    .clk   (clk),
    .clr   (clr),
    .we    (commit && !c_rw && !clr),
    .re    (commit &&  c_rw && !clr),
    .addr  (c_addr),
    .wdata (c_data),
    .rdata (rd_reg)
  );

  // Drive only while a committed read is held and the cache is still
  // asking for a read; release the instant it turns the bus around.
  assign data_io = ((state == HOLD) && rw_l && ce_in && rw_in) ? rd_reg : 'z;

`ifdef MAIN_MEMORY_STATS_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (commit) begin
      if (c_rw) begin
        rd_count <= sat_inc(rd_count);
      end else begin
        wr_count <= sat_inc(wr_count);
      end
    end
  end
`endif

endmodule
